// File: rtl/z80_bus_ctrl_if.sv
// Fabric-side bus of the Z80 bus controller.
//   master: controller side (drives request, payload and error; receives ack and read data)
//   slave : memory/IO target side
// ADDR_W must match the ADDR_W of the z80_bus_ctrl instance this interface is bound to.
interface z80_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic              bus_io;
    logic [7:0]        bus_wdata;
    logic              bus_ack;
    logic [7:0]        bus_rdata;
    logic              bus_err;

    modport master (
        output bus_req, bus_addr, bus_we, bus_io, bus_wdata, bus_err,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_addr, bus_we, bus_io, bus_wdata, bus_err,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/z80_bus_ctrl.sv
// Z80 bus controller: converts CPU strobes into a one-cycle request/ack handshake on the
// fabric bus, stretches the CPU cycle with WAIT_n, forces completion on a missing ack,
// answers IM2 interrupt-acknowledge cycles and generates the periodic frame interrupt.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   cpu_*             CPU address/data/strobes in, cpu_din/cpu_wait_n/cpu_int_n out
//   bus (master)      bus_req/addr/we/io/wdata/err out, bus_ack/bus_rdata in
//   frame_tick        one-cycle pulse when INT_n asserts
module z80_bus_ctrl #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MEM_WAIT    = 0,
    parameter int unsigned IO_WAIT     = 1,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned INT_PERIOD  = 69888,
    parameter int unsigned INT_LEN     = 32,
    parameter logic [7:0]  IM2_VECTOR  = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    input  logic              cpu_mreq_n,
    input  logic              cpu_iorq_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    input  logic              cpu_m1_n,
    output logic              cpu_wait_n,
    output logic              cpu_int_n,
    z80_bus_ctrl_if.master    bus,
    output logic              frame_tick
);
    localparam int unsigned MAX_WAIT = (MEM_WAIT > IO_WAIT) ? MEM_WAIT : IO_WAIT;
    localparam int unsigned WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int unsigned TO_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned PER_W    = $clog2(INT_PERIOD);
    localparam int unsigned LEN_W    = $clog2(INT_LEN + 1);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(INT_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [7:0]          din_q, din_d;
    logic                wait_n_q, wait_n_d;
    logic                int_n_q, int_n_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                io_q, io_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                tick_q, tick_d;
    logic                ack_flag_q, ack_flag_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;

    logic inta, start, hold_exit, timeout, int_ack, to_next, done_next;

    assign inta      = !cpu_iorq_n && !cpu_m1_n;
    assign start     = (!cpu_mreq_n || (!cpu_iorq_n && cpu_m1_n)) && (!cpu_rd_n || !cpu_wr_n);
    assign hold_exit = (cpu_rd_n && cpu_wr_n && cpu_iorq_n) || (cpu_mreq_n && cpu_iorq_n);
    assign timeout   = !ack_flag_q && (to_cnt_q == TO_LAST);

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            din_q      <= 8'hFF;
            wait_n_q   <= 1'b1;
            int_n_q    <= 1'b1;
            req_q      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            io_q       <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            tick_q     <= 1'b0;
            ack_flag_q <= 1'b0;
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
            per_cnt_q  <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            din_q      <= din_d;
            wait_n_q   <= wait_n_d;
            int_n_q    <= int_n_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            io_q       <= io_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            tick_q     <= tick_d;
            ack_flag_q <= ack_flag_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            per_cnt_q  <= per_cnt_d;
            len_q      <= len_d;
        end
    end

    // Next-state, datapath and interrupt generator
    always_comb begin
        state_d    = state_q;
        din_d      = din_q;
        addr_d     = addr_q;
        we_d       = we_q;
        io_d       = io_q;
        wdata_d    = wdata_q;
        ack_flag_d = ack_flag_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        per_cnt_d  = per_cnt_q;
        len_d      = len_q;
        int_n_d    = int_n_q;
        tick_d     = 1'b0;
        int_ack    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (inta) begin
                    din_d   = IM2_VECTOR;
                    int_ack = 1'b1;
                    state_d = S_HOLD;
                end else if (start) begin
                    addr_d     = cpu_addr;
                    we_d       = !cpu_wr_n;
                    io_d       = cpu_mreq_n;
                    wdata_d    = cpu_dout;
                    wait_cnt_d = cpu_mreq_n ? WAIT_W'(IO_WAIT) : WAIT_W'(MEM_WAIT);
                    ack_flag_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                to_cnt_d = '0;
                if (bus.bus_ack) begin
                    ack_flag_d = 1'b1;
                    if (!we_q) din_d = bus.bus_rdata;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timeout || (ack_flag_q && wait_cnt_q == '0)) begin
                    state_d = S_HOLD;
                end else begin
                    if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    // only the first ack of a cycle carries data
                    if (bus.bus_ack && !ack_flag_q) begin
                        ack_flag_d = 1'b1;
                        if (!we_q) din_d = bus.bus_rdata;
                    end
                end
            end
            S_HOLD: begin
                if (hold_exit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Completion is decided from registers, so it can be predicted one cycle ahead;
        // this lets WAIT_n, bus_err and the timeout data be registered yet line up with it.
        to_next   = (state_d == S_WAIT) && !ack_flag_d && (to_cnt_d == TO_LAST);
        done_next = (state_d == S_WAIT) && ((ack_flag_d && wait_cnt_d == '0) || to_next);
        wait_n_d  = !((state_d == S_REQ) || ((state_d == S_WAIT) && !done_next));
        req_d     = (state_d == S_REQ);
        err_d     = to_next;
        if (to_next) din_d = 8'hFF;

        // Frame interrupt: a wrap starts (or restarts) the pulse and wins over INTA
        if (per_cnt_q == PER_LAST) begin
            per_cnt_d = '0;
            int_n_d   = 1'b0;
            len_d     = LEN_W'(INT_LEN);
            tick_d    = 1'b1;
        end else begin
            per_cnt_d = per_cnt_q + PER_W'(1);
            if (int_ack) begin
                int_n_d = 1'b1;
                len_d   = '0;
            end else if (len_q != '0) begin
                len_d = len_q - LEN_W'(1);
                if (len_q == LEN_W'(1)) int_n_d = 1'b1;
            end
        end
    end

    assign cpu_din       = din_q;
    assign cpu_wait_n    = wait_n_q;
    assign cpu_int_n     = int_n_q;
    assign frame_tick    = tick_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_io    = io_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_err   = err_q;
endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Self-checking bench for z80_bus_ctrl: scoreboarded bus cycles, reset, frame interrupt, INTA.
`timescale 1ns/1ps
module tb_z80_bus_ctrl;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned MEM_WAIT    = 0;
    localparam int unsigned IO_WAIT     = 2;
    localparam int unsigned ACK_TIMEOUT = 8;
    localparam int unsigned INT_PERIOD  = 100;
    localparam int unsigned INT_LEN     = 10;
    localparam logic [7:0]  IM2_VECTOR  = 8'hA5;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_dout;
    logic [7:0]        cpu_din;
    logic              cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
    logic              cpu_wait_n, cpu_int_n, frame_tick;

    z80_bus_ctrl_if #(.ADDR_W(ADDR_W)) bif ();

    z80_bus_ctrl #(
        .ADDR_W(ADDR_W), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .ACK_TIMEOUT(ACK_TIMEOUT),
        .INT_PERIOD(INT_PERIOD), .INT_LEN(INT_LEN), .IM2_VECTOR(IM2_VECTOR)
    ) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n),
        .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n), .cpu_wait_n(cpu_wait_n),
        .cpu_int_n(cpu_int_n), .bus(bif), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic              io;
        logic [7:0]        wdata;
        logic [7:0]        din;
        int                wait_low;
        logic              err;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] model_din = 8'hFF;
    int         resp_delay = -1;
    logic [7:0] resp_rdata = 8'h00;
    bit         resp_extra = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_din"},    32'(cpu_din),        32'hFF);
        check({tag, "_wait_n"}, 32'(cpu_wait_n),     32'd1);
        check({tag, "_int_n"},  32'(cpu_int_n),      32'd1);
        check({tag, "_req"},    32'(bif.bus_req),    32'd0);
        check({tag, "_addr"},   32'(bif.bus_addr),   32'd0);
        check({tag, "_we"},     32'(bif.bus_we),     32'd0);
        check({tag, "_io"},     32'(bif.bus_io),     32'd0);
        check({tag, "_wdata"},  32'(bif.bus_wdata),  32'd0);
        check({tag, "_err"},    32'(bif.bus_err),    32'd0);
        check({tag, "_tick"},   32'(frame_tick),     32'd0);
    endtask

    task automatic strobes_idle();
        cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
    endtask

    // Target model: acks resp_delay cycles after bus_req (never if negative), optional late second ack
    initial begin
        int  cnt;
        bit  busy;
        cnt = 0;
        busy = 1'b0;
        bif.bus_ack = 1'b0;
        bif.bus_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            bif.bus_ack = 1'b0;
            bif.bus_rdata = 8'h00;
            if (reset) begin
                busy = 1'b0;
            end else begin
                if (bif.bus_req) begin
                    busy = 1'b1;
                    cnt = 0;
                    if (exp_q.size() == 0) begin
                        check("req_unexpected", 32'(bif.bus_req), 32'd0);
                    end else begin
                        check("req_addr",  32'(bif.bus_addr),  32'(exp_q[0].addr));
                        check("req_we",    32'(bif.bus_we),    32'(exp_q[0].we));
                        check("req_io",    32'(bif.bus_io),    32'(exp_q[0].io));
                        check("req_wdata", 32'(bif.bus_wdata), 32'(exp_q[0].wdata));
                    end
                end else if (busy) begin
                    cnt++;
                end
                if (busy && cnt == resp_delay) begin
                    bif.bus_ack = 1'b1;
                    bif.bus_rdata = resp_rdata;
                    if (!resp_extra) busy = 1'b0;
                end else if (busy && resp_extra && cnt == resp_delay + 2) begin
                    bif.bus_ack = 1'b1;
                    bif.bus_rdata = 8'h99;
                    busy = 1'b0;
                end
            end
        end
    end

    // One CPU bus cycle: expectation pushed at drive time, popped and compared at completion
    task automatic cpu_cycle(input bit io, input bit wr, input logic [ADDR_W-1:0] addr,
                             input logic [7:0] wdata, input logic [7:0] rdata,
                             input int delay, input bit extra);
        exp_t e;
        int   wl;
        int   lowc, errc, reqc;
        bit   done;
        lowc = 0; errc = 0; reqc = 0; done = 1'b0;
        wl = io ? int'(IO_WAIT) : int'(MEM_WAIT);
        e.addr = addr; e.we = wr; e.io = io; e.wdata = wdata;
        if (delay < 0) begin
            e.din = 8'hFF; e.wait_low = int'(ACK_TIMEOUT); e.err = 1'b1;
        end else begin
            e.din = wr ? model_din : rdata;
            e.wait_low = 1 + ((wl > delay) ? wl : delay);
            e.err = 1'b0;
        end
        model_din = e.din;
        resp_delay = delay; resp_rdata = rdata; resp_extra = extra;
        exp_q.push_back(e);
        cpu_addr = addr; cpu_dout = wdata; cpu_m1_n = 1'b1;
        cpu_mreq_n = io; cpu_iorq_n = !io; cpu_rd_n = wr; cpu_wr_n = !wr;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            if (bif.bus_req) reqc++;
            if (bif.bus_err) errc++;
            if (!cpu_wait_n) lowc++;
            else if (lowc > 0) done = 1'b1;
        end
        check("complete", 32'(done), 32'd1);
        e = exp_q.pop_front();
        check("din", 32'(cpu_din), 32'(e.din));
        check("wait_low", 32'(lowc), 32'(e.wait_low));
        repeat (3) begin
            @(posedge clk); #1;
            if (bif.bus_req) reqc++;
            if (bif.bus_err) errc++;
            if (!cpu_wait_n) lowc++;
        end
        check("req_pulses", 32'(reqc), 32'd1);
        check("err_pulses", 32'(errc), 32'(e.err));
        check("din_hold", 32'(cpu_din), 32'(e.din));
        check("wait_hold", 32'(lowc), 32'(e.wait_low));
        strobes_idle();
        repeat (2) begin @(posedge clk); #1; end
        check("addr_stable", 32'(bif.bus_addr), 32'(addr));
        check("io_stable", 32'(bif.bus_io), 32'(io));
        check("we_stable", 32'(bif.bus_we), 32'(wr));
        check("wdata_stable", 32'(bif.bus_wdata), 32'(wdata));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   exp_low;
        reset = 1'b1;
        cpu_addr = '0; cpu_dout = '0;
        strobes_idle();
        repeat (3) @(posedge clk);
        #1;
        check_reset("init");
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        cpu_cycle(1'b0, 1'b0, 16'h1000, 8'h00, 8'h3C, 0, 1'b1);   // zero-wait read, late 2nd ack
        cpu_cycle(1'b1, 1'b1, 16'h00FE, 8'h77, 8'hEE, 0, 1'b0);   // IO write, 2 waits
        cpu_cycle(1'b0, 1'b0, 16'h2345, 8'h00, 8'hC7, 5, 1'b0);   // slow target
        cpu_cycle(1'b0, 1'b0, 16'h4000, 8'h00, 8'h12, -1, 1'b0);  // no ack -> timeout
        cpu_cycle(1'b0, 1'b0, 16'h8001, 8'h00, 8'h5E, 2, 1'b0);   // read after timeout
        cpu_cycle(1'b0, 1'b1, 16'h8002, 8'h11, 8'hEE, 0, 1'b0);   // write keeps din
        cpu_cycle(1'b1, 1'b0, 16'h00FF, 8'h00, 8'h42, 1, 1'b0);   // IO read, waits dominate

        // Reset in the middle of a stretched IO write
        e.addr = 16'h1234; e.we = 1'b1; e.io = 1'b1; e.wdata = 8'h5A;
        e.din = 8'hFF; e.wait_low = 0; e.err = 1'b0;
        exp_q.push_back(e);
        resp_delay = -1; resp_extra = 1'b0;
        cpu_addr = 16'h1234; cpu_dout = 8'h5A;
        cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b1; cpu_wr_n = 1'b0; cpu_m1_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("pre_rst_wait_n", 32'(cpu_wait_n), 32'd0);
        check("pre_rst_io", 32'(bif.bus_io), 32'd1);
        #2 reset = 1'b1;
        #1 check_reset("mid");
        strobes_idle();
        exp_q.delete();
        model_din = 8'hFF;
        @(posedge clk); #1;
        reset = 1'b0;

        // Frame interrupt timing from reset release, with an INTA inside the third pulse
        for (int c = 1; c <= 320; c++) begin
            @(posedge clk); #1;
            exp_low = (c >= 100) && ((c % 100) < 10) && !(c >= 304 && c < 310);
            check("int_n", 32'(cpu_int_n), 32'(!exp_low));
            check("frame_tick", 32'(frame_tick), 32'((c % 100) == 0));
            if (c >= 303 && c <= 310) begin
                check("inta_no_req", 32'(bif.bus_req), 32'd0);
                check("inta_wait_n", 32'(cpu_wait_n), 32'd1);
            end
            if (c == 304) check("inta_din", 32'(cpu_din), 32'(IM2_VECTOR));
            if (c == 303) begin cpu_iorq_n = 1'b0; cpu_m1_n = 1'b0; end
            if (c == 305) begin cpu_iorq_n = 1'b1; cpu_m1_n = 1'b1; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
